// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control signal bundle between the datapath and hazard_ctrl_unit.
// master: the datapath side that drives pipeline state and receives the controls; slave: the hazard unit.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic             idex_memread;
    logic             exmem_regwrite;
    logic             memwb_regwrite;
    logic [REG_W-1:0] exmem_dest;
    logic [REG_W-1:0] memwb_dest;
    logic             branch_taken;
    logic             md_start;
    logic             ifid_md_use;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             md_busy;

    modport master (
        output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
               exmem_regwrite, memwb_regwrite, exmem_dest, memwb_dest,
               branch_taken, md_start, ifid_md_use,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a, fwd_b, md_busy
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
               exmem_regwrite, memwb_regwrite, exmem_dest, memwb_dest,
               branch_taken, md_start, ifid_md_use,
        output pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a, fwd_b, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: load-use stall FSM, mult/div busy counter, branch flush and
// EX operand forwarding select. All control outputs are combinational.
module hazard_ctrl_unit #(
    parameter int REG_W          = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int MD_LAT         = 4
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hif
);
    typedef enum logic {
        IDLE,
        LSTALL
    } lstate_t;

    localparam logic [3:0] LCNT_INIT = 4'(LOAD_STALL_CYC - 1);
    localparam logic [5:0] MCNT_INIT = 6'(MD_LAT);

    lstate_t    state;
    lstate_t    state_nxt;
    logic [3:0] lcnt;
    logic [3:0] lcnt_nxt;
    logic [5:0] mcnt;
    logic       luh;
    logic       load_stall;
    logic       md_busy_int;
    logic       stall;

    assign luh = hif.idex_memread && (hif.idex_rt != '0) &&
                 ((hif.idex_rt == hif.ifid_rs) || (hif.idex_rt == hif.ifid_rt));

    assign md_busy_int = (mcnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lcnt  <= '0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        lcnt_nxt   = lcnt;
        load_stall = 1'b0;
        case (state)
            IDLE: begin
                if (luh && !hif.branch_taken) begin
                    load_stall = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        state_nxt = LSTALL;
                        lcnt_nxt  = LCNT_INIT;
                    end
                end
            end
            LSTALL: begin
                load_stall = 1'b1;
                lcnt_nxt   = lcnt - 4'd1;
                if (lcnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                lcnt_nxt  = '0;
            end
        endcase
        // A taken branch squashes the stalled instruction, so any load stall is abandoned.
        if (hif.branch_taken) begin
            state_nxt = IDLE;
            lcnt_nxt  = '0;
        end
    end

    // A new issue restarts the latency count even if the unit is still busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= '0;
        end else if (hif.md_start) begin
            mcnt <= MCNT_INIT;
        end else if (mcnt != '0) begin
            mcnt <= mcnt - 6'd1;
        end
    end

    assign stall = load_stall || (md_busy_int && hif.ifid_md_use);

    always_comb begin
        hif.pc_write    = 1'b1;
        hif.ifid_write  = 1'b1;
        hif.idex_bubble = 1'b0;
        hif.ifid_flush  = 1'b0;
        hif.md_busy     = md_busy_int;
        if (rst) begin
            hif.pc_write    = 1'b0;
            hif.ifid_write  = 1'b0;
            hif.idex_bubble = 1'b1;
            hif.ifid_flush  = 1'b1;
            hif.md_busy     = 1'b0;
        end else if (hif.branch_taken) begin
            hif.idex_bubble = 1'b1;
            hif.ifid_flush  = 1'b1;
        end else if (stall) begin
            hif.pc_write    = 1'b0;
            hif.ifid_write  = 1'b0;
            hif.idex_bubble = 1'b1;
        end
    end

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    always_comb begin
        hif.fwd_a = 2'b00;
        hif.fwd_b = 2'b00;
        if (!rst) begin
            if (hif.exmem_regwrite && (hif.exmem_dest != '0) && (hif.exmem_dest == hif.idex_rs)) begin
                hif.fwd_a = 2'b10;
            end else if (hif.memwb_regwrite && (hif.memwb_dest != '0) && (hif.memwb_dest == hif.idex_rs)) begin
                hif.fwd_a = 2'b01;
            end
            if (hif.exmem_regwrite && (hif.exmem_dest != '0) && (hif.exmem_dest == hif.idex_rt)) begin
                hif.fwd_b = 2'b10;
            end else if (hif.memwb_regwrite && (hif.memwb_dest != '0) && (hif.memwb_dest == hif.idex_rt)) begin
                hif.fwd_b = 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one instance with single-cycle load stall,
// one with three-cycle load stall; both with a four-cycle mult/div latency.
module tb_hazard_ctrl_unit;
    localparam logic [7:0] RUN  = 8'h0C; // {pc_write, ifid_write, idex_bubble, ifid_flush}
    localparam logic [7:0] STL  = 8'h02;
    localparam logic [7:0] FLS  = 8'h0F;
    localparam logic [7:0] RSTV = 8'h03;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    hazard_ctrl_if #(.REG_W(5)) h1 ();
    hazard_ctrl_if #(.REG_W(5)) h3 ();

    hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL_CYC(1), .MD_LAT(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .hif (h1.slave)
    );

    hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL_CYC(3), .MD_LAT(4)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .hif (h3.slave)
    );

    logic [7:0] ctrl1;
    logic [7:0] ctrl3;
    assign ctrl1 = {4'b0000, h1.pc_write, h1.ifid_write, h1.idex_bubble, h1.ifid_flush};
    assign ctrl3 = {4'b0000, h3.pc_write, h3.ifid_write, h3.idex_bubble, h3.ifid_flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr();
        h1.ifid_rs = 5'd0;  h1.ifid_rt = 5'd0;  h1.idex_rs = 5'd0;  h1.idex_rt = 5'd0;
        h1.idex_memread = 1'b0; h1.exmem_regwrite = 1'b0; h1.memwb_regwrite = 1'b0;
        h1.exmem_dest = 5'd0; h1.memwb_dest = 5'd0; h1.branch_taken = 1'b0;
        h1.md_start = 1'b0; h1.ifid_md_use = 1'b0;
        h3.ifid_rs = 5'd0;  h3.ifid_rt = 5'd0;  h3.idex_rs = 5'd0;  h3.idex_rt = 5'd0;
        h3.idex_memread = 1'b0; h3.exmem_regwrite = 1'b0; h3.memwb_regwrite = 1'b0;
        h3.exmem_dest = 5'd0; h3.memwb_dest = 5'd0; h3.branch_taken = 1'b0;
        h3.md_start = 1'b0; h3.ifid_md_use = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        clr();
        h1.exmem_regwrite = 1'b1; h1.exmem_dest = 5'd7;
        h1.memwb_regwrite = 1'b1; h1.memwb_dest = 5'd7; h1.idex_rs = 5'd7;
        #2;
        chk("rst_ctl1", ctrl1, RSTV);
        chk("rst_ctl3", ctrl3, RSTV);
        chk("rst_fwd_a", 8'(h1.fwd_a), 8'd0);
        chk("rst_busy", 8'(h1.md_busy), 8'd0);

        // forwarding priority and zero-register exclusion
        cyc();
        rst = 1'b0;
        settle();
        chk("fwd_a_exmem", 8'(h1.fwd_a), 8'd2);
        chk("ctl_after_rst", ctrl1, RUN);
        h1.exmem_regwrite = 1'b0;
        settle();
        chk("fwd_a_memwb", 8'(h1.fwd_a), 8'd1);
        h1.exmem_regwrite = 1'b1; h1.exmem_dest = 5'd0; h1.memwb_dest = 5'd0; h1.idex_rs = 5'd0;
        settle();
        chk("fwd_a_zero", 8'(h1.fwd_a), 8'd0);
        h1.idex_rs = 5'd3; h1.idex_rt = 5'd9; h1.exmem_dest = 5'd3; h1.memwb_dest = 5'd9;
        h1.memwb_regwrite = 1'b1;
        settle();
        chk("fwd_a_mix", 8'(h1.fwd_a), 8'd2);
        chk("fwd_b_mix", 8'(h1.fwd_b), 8'd1);

        // single-cycle load-use stall
        cyc();
        clr();
        h1.idex_memread = 1'b1; h1.idex_rt = 5'd5; h1.ifid_rt = 5'd5;
        settle();
        chk("ld1_stall", ctrl1, STL);
        cyc();
        h1.idex_memread = 1'b0;
        settle();
        chk("ld1_release", ctrl1, RUN);
        cyc();
        h1.idex_memread = 1'b1; h1.idex_rt = 5'd0; h1.ifid_rt = 5'd0;
        settle();
        chk("ld1_r0", ctrl1, RUN);
        h1.idex_rt = 5'd5; h1.ifid_rs = 5'd3; h1.ifid_rt = 5'd4;
        settle();
        chk("ld1_nomatch", ctrl1, RUN);

        // three-cycle load-use stall
        cyc();
        clr();
        h3.idex_memread = 1'b1; h3.idex_rt = 5'd6; h3.ifid_rs = 5'd6;
        settle();
        chk("ld3_c0", ctrl3, STL);
        cyc(); settle();
        chk("ld3_c1", ctrl3, STL);
        cyc(); settle();
        chk("ld3_c2", ctrl3, STL);
        cyc();
        h3.idex_memread = 1'b0;
        settle();
        chk("ld3_c3", ctrl3, RUN);

        // branch taken during LSTALL with lcnt = 2
        cyc();
        h3.idex_memread = 1'b1;
        settle();
        chk("br_pre", ctrl3, STL);
        cyc();
        h3.branch_taken = 1'b1; h3.idex_memread = 1'b0;
        settle();
        chk("br_flush", ctrl3, FLS);
        cyc();
        h3.branch_taken = 1'b0;
        settle();
        chk("br_next", ctrl3, RUN);

        // mult/div busy stall
        cyc();
        clr();
        h1.md_start = 1'b1; h1.ifid_md_use = 1'b1;
        settle();
        chk("md_issue_busy", 8'(h1.md_busy), 8'd0);
        chk("md_issue_ctl", ctrl1, RUN);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            h1.md_start = 1'b0;
            settle();
            chk($sformatf("md_busy_%0d", i), 8'(h1.md_busy), 8'd1);
            chk($sformatf("md_stall_%0d", i), ctrl1, STL);
        end
        cyc(); settle();
        chk("md_done_busy", 8'(h1.md_busy), 8'd0);
        chk("md_done_ctl", ctrl1, RUN);

        cyc();
        h1.md_start = 1'b1; h1.ifid_md_use = 1'b0;
        cyc();
        h1.md_start = 1'b0;
        settle();
        chk("md_nouse_busy", 8'(h1.md_busy), 8'd1);
        chk("md_nouse_ctl", ctrl1, RUN);
        cyc();
        cyc();
        h1.md_start = 1'b1;
        cyc();
        h1.md_start = 1'b0;
        cyc(); cyc(); cyc();
        settle();
        chk("md_reload_tail", 8'(h1.md_busy), 8'd1);
        cyc(); settle();
        chk("md_reload_end", 8'(h1.md_busy), 8'd0);

        // asynchronous reset mid-LSTALL with mcnt = 3
        cyc();
        clr();
        h3.md_start = 1'b1;
        cyc();
        h3.md_start = 1'b0;
        h3.idex_memread = 1'b1; h3.idex_rt = 5'd6; h3.ifid_rs = 5'd6;
        h3.exmem_regwrite = 1'b1; h3.exmem_dest = 5'd6; h3.idex_rs = 5'd6;
        settle();
        chk("ar_pre_ctl", ctrl3, STL);
        chk("ar_pre_busy", 8'(h3.md_busy), 8'd1);
        cyc(); settle();
        chk("ar_mid_ctl", ctrl3, STL);
        chk("ar_mid_fwd", 8'(h3.fwd_a), 8'd2);
        rst = 1'b1;
        #1;
        chk("ar_rst_ctl", ctrl3, RSTV);
        chk("ar_rst_busy", 8'(h3.md_busy), 8'd0);
        chk("ar_rst_fwd", 8'(h3.fwd_a), 8'd0);
        cyc();
        h3.idex_memread = 1'b0; h3.ifid_md_use = 1'b1;
        rst = 1'b0;
        settle();
        chk("ar_rel_ctl", ctrl3, RUN);
        chk("ar_rel_busy", 8'(h3.md_busy), 8'd0);
        cyc(); settle();
        chk("ar_rel_ctl2", ctrl3, RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_W, default 5: register-address width.
REQ-002 Parameter LOAD_STALL_CYC, default 1, legal 1..15: total stall cycles per load-use hazard.
REQ-003 Parameter MD_LAT, default 4, legal 1..63: mult/div busy cycles after issue.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Ports ifid_rs, ifid_rt  input  REG_W  source registers of the ID-stage instruction.
REQ-007 Ports idex_rs, idex_rt  input  REG_W  source registers of the EX-stage instruction.
REQ-008 Port idex_memread  input  1  EX-stage instruction is a load (destination idex_rt).
REQ-009 Ports exmem_regwrite, memwb_regwrite  input  1  MEM/WB-stage instruction writes the register file.
REQ-010 Ports exmem_dest, memwb_dest  input  REG_W  MEM/WB-stage destination registers.
REQ-011 Port branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-012 Port md_start  input  1  one-cycle pulse: mult/div issued from EX.
REQ-013 Port ifid_md_use  input  1  ID-stage instruction reads HI/LO or is a mult/div.
REQ-014 Ports pc_write, ifid_write  output  1  PC and IF/ID register enables.
REQ-015 Port idex_bubble  output  1  zero control fields written into ID/EX.
REQ-016 Port ifid_flush  output  1  clear IF/ID to NOP.
REQ-017 Ports fwd_a, fwd_b  output  2  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-018 Port md_busy  output  1  mult/div unit busy.

Function
REQ-019 Load-use hazard (luh) SHALL be: idex_memread AND idex_rt != 0 AND (idex_rt == ifid_rs OR idex_rt == ifid_rt).
REQ-020 Load FSM states: IDLE and LSTALL; 4-bit down-counter lcnt.
REQ-021 In IDLE with luh and no branch_taken: stall asserted same cycle; if LOAD_STALL_CYC > 1, go to LSTALL with lcnt = LOAD_STALL_CYC-1, else remain IDLE.
REQ-022 In LSTALL: stall asserted; lcnt decrements each cycle; transition to IDLE on the edge where lcnt == 1.
REQ-023 Mult/div counter mcnt (6 bit): md_start loads MD_LAT (even if already nonzero); otherwise decrements while nonzero; md_busy = (mcnt != 0).
REQ-024 stall SHALL be: (load stall per REQ-021/022) OR (md_busy AND ifid_md_use).
REQ-025 stall SHALL force pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0.
REQ-026 No stall and no branch: pc_write = 1, ifid_write = 1, idex_bubble = 0, ifid_flush = 0.
REQ-027 branch_taken SHALL override stall: pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_bubble = 1; load FSM forced to IDLE next edge; mcnt unaffected.
REQ-028 fwd_a = 10 if exmem_regwrite AND exmem_dest != 0 AND exmem_dest == idex_rs; else 01 if the same holds for memwb_*; else 00. fwd_b identical with idex_rt. EX/MEM has priority.
REQ-029 Forwarding, stall and flush outputs SHALL be combinational from inputs and current state (zero-cycle latency).

Reset
REQ-030 While rst is high: load FSM = IDLE, lcnt = 0, mcnt = 0, pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 1, fwd_a = fwd_b = 00, md_busy = 0.
REQ-031 Reset asserted mid-stall or mid-mult/div SHALL abort both immediately; first cycle after release behaves as IDLE with mcnt = 0.

Verification
REQ-032 LOAD_STALL_CYC=1, idex_memread=1, idex_rt=5, ifid_rt=5 -> exactly 1 cycle pc_write=0, idex_bubble=1; with idex_rt=0 -> no stall.
REQ-033 LOAD_STALL_CYC=3, luh on ifid_rs -> stall for 3 consecutive cycles, then pc_write=1 with no further input change.
REQ-034 MD_LAT=4, md_start pulse, then ifid_md_use=1 held -> md_busy=1 and stall for 4 cycles; ifid_md_use=0 -> md_busy=1 but no stall.
REQ-035 exmem_dest=memwb_dest=idex_rs=7, both regwrite=1 -> fwd_a=10; exmem_regwrite=0 -> fwd_a=01; all dest=0 -> fwd_a=00.
REQ-036 branch_taken during LSTALL with lcnt=2 -> same-cycle ifid_flush=1, pc_write=1; next cycle IDLE, no stall.
REQ-037 rst pulse asserted mid-LSTALL with mcnt=3 -> outputs take REQ-030 values asynchronously; after release md_busy=0, no stall.
